decode_scan: RTL and testbench
==============================

// Module: decode_scan
// PURPOSE
//  Registered, parametrised N-to-U decoder with three output modes:
//  - static one-hot
//  - auto-scanning one-hot (ring walk at a prescaled rate)
//  - thermometer
//  Drives digit/row selects for multiplexed displays and keypads, and chip-selects
//  from a latched address. Successor to the combinational decoder: adds a clock,
//  load/enable control, range checking and a scan sequencer.
// PARAMETERS
//  N    4  width of address input x_in and index register idx
//  U    8  number of outputs, 1 <= U <= 2**N
//  DIV  4  clock cycles per scan step, >= 1; DIV=1 steps every enabled cycle
// PORTS
//  clk     in   1  single clock, rising edge
//  rst_n   in   1  asynchronous, active-low reset
//  en      in   1  global enable; 0 freezes every register, outputs held
//  mode    in   2  00 static, 01 scan, 10 thermometer, 11 reserved (acts as 00)
//  x_in    in   N  address to load
//  load    in   1  capture x_in into idx (qualified by en)
//  y_out   out  U  decoded select outputs, registered
//  idx     out  N  current index
//  err     out  1  loaded address >= U (static/thermo), registered
//  wrap    out  1  1-cycle pulse when scan steps from idx=U-1 to 0
// BEHAVIOUR
//  - Reset (async, rst_n=0): idx=0, prescaler=0, y_out=0, err=0, wrap=0.
//    After reset release, y_out stays 0 until the first enabled clock edge.
//  - All outputs are registered. y_out reflects the idx/mode of the previous edge.
//  - Static latency: load -> y_out/err = 1 cycle.
//  - Static (00/11):
//    - load&en: idx<=x_in, err<=(x_in>=U).
//    - Next cycle: y_out[i]=(idx==i).
//    - If x_in>=U: y_out=0, err=1. err holds until the next load.
//  - Thermometer (10): y_out[i]=(i<=idx). Out-of-range handling and err as static.
//  - Scan (01):
//    - Prescaler counts 0..DIV-1 on en. At DIV-1 it is a tick: prescaler<=0,
//      idx<=(idx==U-1)?0:idx+1.
//    - wrap=1 on the cycle after the U-1->0 step, otherwise 0.
//    - y_out = one-hot of idx; err=0.
//    - idx>=U on entry to scan (from an earlier static load) wraps to 0 on the next tick.
//  - load&en in scan mode: idx<=x_in (x_in>=U -> idx<=0, err<=1 for one cycle),
//    prescaler<=0. load has priority over a simultaneous tick; no wrap pulse.
//  - Mode change: prescaler<=0 on the edge where the mode differs from its registered
//    copy. idx is preserved. New decode appears on y_out one cycle later.
//  - en=0: prescaler, idx, y_out, err hold; wrap<=0; load is ignored.
//  - Widths: idx compares are N-bit unsigned. The prescaler is $clog2(DIV)+1 bits.
//    The U-1 compare is sized to N.
// CONFIGURATION
//  - DECODE_SCAN_BLANK_EN defined:
//    - Scan mode only: y_out is forced to 0 for exactly one cycle after every idx
//      change (tick or load), giving anti-ghosting dead time.
//    - wrap timing is unchanged.
//    - Has effect only when DIV>=2; with DIV=1, blanking is suppressed.
//  - DECODE_SCAN_BLANK_EN undefined: no blanking; y_out switches directly between
//    adjacent one-hot codes.
// TESTING
//  (defaults N=4, U=8, DIV=4)
//  1. Reset and static decode: rst_n=0 -> all outputs 0. Release; mode=00, x_in=5,
//     load=1, en=1 for one cycle -> next cycle y_out=8'b0010_0000, idx=5, err=0.
//  2. Out of range: static load x_in=12 -> y_out=0, err=1. Load x_in=2 -> err=0,
//     y_out=8'h04. Thermometer mode with idx=2 -> y_out=8'h07.
//  3. Scan walk: mode=01 from idx=0, en=1 held -> idx increments every 4 cycles,
//     0..7,0. wrap is high for one cycle right after the 7->0 step. One full ring
//     takes 32 cycles.
//  4. Load vs tick: in scan, assert load with x_in=3 on a tick cycle -> idx=3,
//     prescaler restarts, no wrap, next step to 4 occurs 4 cycles later.
//  5. Freeze and async reset: deassert en mid-scan at idx=6 -> outputs held over
//     10 cycles. Pull rst_n low between clock edges -> y_out=0 and idx=0 immediately,
//     without waiting for a clock edge.
//  6. With DECODE_SCAN_BLANK_EN: scan -> y_out=0 for 1 cycle after each step, then
//     one-hot for 3 cycles. Rebuild with DIV=1 -> no blanking.

Source files
------------

// File: rtl/decode_scan_if.sv
// rtl/decode_scan_if.sv - control/select bundle between a decode_scan and its driver
interface decode_scan_if #(
  parameter int N = 4,
  parameter int U = 8
);
  logic         en;
  logic [1:0]   mode;
  logic [N-1:0] x_in;
  logic         load;
  logic [U-1:0] y_out;
  logic [N-1:0] idx;
  logic         err;
  logic         wrap;

  modport master (
    output en, mode, x_in, load,
    input  y_out, idx, err, wrap
  );

  modport slave (
    input  en, mode, x_in, load,
    output y_out, idx, err, wrap
  );
endinterface

// File: rtl/decode_scan.sv
// rtl/decode_scan.sv - registered N-to-U one-hot/scan/thermometer decoder; DECODE_SCAN_BLANK_EN adds scan blanking
module decode_scan #(
  parameter int N   = 4,
  parameter int U   = 8,
  parameter int DIV = 4
) (
  input logic         clk,
  input logic         rst_n,
  decode_scan_if.slave bus
);

  localparam int             PW       = $clog2(DIV) + 1;
  localparam logic [PW-1:0]  DIV_LAST = PW'(DIV - 1);
  localparam logic [N-1:0]   LAST     = N'(U - 1);
  localparam logic [N:0]     U_W      = (N + 1)'(U);

  logic [N-1:0]  idx_q, idx_n;
  logic [PW-1:0] presc_q, presc_n;
  logic [U-1:0]  y_q, y_n, dec;
  logic          err_q, err_n;
  logic          wrap_q, wrap_n;
  logic [1:0]    mode_q;
  logic          is_scan, is_thermo, mode_chg, oor, step;

  assign is_scan   = (bus.mode == 2'b01);
  assign is_thermo = (bus.mode == 2'b10);
  assign mode_chg  = (bus.mode != mode_q);
  assign oor       = ({1'b0, bus.x_in} >= U_W);

  // Next index, prescaler and flags; load beats tick, a mode change restarts the prescaler
  always_comb begin
    idx_n   = idx_q;
    presc_n = presc_q;
    err_n   = err_q;
    wrap_n  = 1'b0;
    step    = 1'b0;
    if (is_scan) begin
      err_n = 1'b0;
      if (bus.load) begin
        idx_n   = oor ? '0 : bus.x_in;
        err_n   = oor;
        presc_n = '0;
        step    = 1'b1;
      end else if (mode_chg) begin
        presc_n = '0;
      end else if (presc_q >= DIV_LAST) begin
        presc_n = '0;
        idx_n   = (idx_q >= LAST) ? '0 : idx_q + N'(1);
        wrap_n  = (idx_q == LAST);
        step    = 1'b1;
      end else begin
        presc_n = presc_q + PW'(1);
      end
    end else begin
      presc_n = '0;
      if (bus.load) begin
        idx_n = bus.x_in;
        err_n = oor;
      end
    end
  end

  // Decode the index being registered so y_out and idx always agree
  always_comb begin
    dec = '0;
    for (int i = 0; i < U; i++) begin
      if (is_thermo) dec[i] = (N'(i) <= idx_n);
      else           dec[i] = (idx_n == N'(i));
    end
    if ({1'b0, idx_n} >= U_W) dec = '0;
  end

`ifdef DECODE_SCAN_BLANK_EN
  localparam bit BLANK_OK = (DIV >= 2);

  // Dead time: blank the selects for the cycle following each scan index change
  always_comb begin
    y_n = dec;
    if (BLANK_OK && is_scan && step) y_n = '0;
  end
`else
  // Selects switch directly between adjacent codes
  always_comb begin
    y_n = dec;
  end
`endif

  // State registers; en low freezes everything except the wrap pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      presc_q <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
      mode_q  <= 2'b00;
    end else if (bus.en) begin
      idx_q   <= idx_n;
      presc_q <= presc_n;
      y_q     <= y_n;
      err_q   <= err_n;
      wrap_q  <= wrap_n;
      mode_q  <= bus.mode;
    end else begin
      wrap_q  <= 1'b0;
    end
  end

  assign bus.y_out = y_q;
  assign bus.idx   = idx_q;
  assign bus.err   = err_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_decode_scan.sv
// tb/tb_decode_scan.sv - directed self-checking bench for decode_scan (N=4, U=8, DIV=4)
module tb_decode_scan;

`ifdef DECODE_SCAN_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  decode_scan_if #(.N(4), .U(8)) bus ();

  decode_scan #(.N(4), .U(8), .DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bus.en = 1'b0; bus.mode = 2'b00; bus.x_in = 4'd0; bus.load = 1'b0;
    cyc(2);
    n_chk++; if (bus.y_out !== 8'h00) begin n_fail++; $display("FAIL reset_y: got %h expected 00", bus.y_out); end
    n_chk++; if (bus.idx !== 4'd0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", bus.idx); end
    n_chk++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    n_chk++; if (bus.wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b expected 0", bus.wrap); end
    rst_n = 1'b1;
    cyc(1);
    n_chk++; if (bus.y_out !== 8'h00) begin n_fail++; $display("FAIL reset_hold_y: got %h expected 00", bus.y_out); end
  endtask

  task automatic test_static;
    bus.en = 1'b1; bus.mode = 2'b00; bus.x_in = 4'd5; bus.load = 1'b1;
    cyc(1);
    bus.load = 1'b0;
    n_chk++; if (bus.y_out !== 8'h20) begin n_fail++; $display("FAIL static_y: got %h expected 20", bus.y_out); end
    n_chk++; if (bus.idx !== 4'd5) begin n_fail++; $display("FAIL static_idx: got %0d expected 5", bus.idx); end
    n_chk++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL static_err: got %b expected 0", bus.err); end
    cyc(1);
    n_chk++; if (bus.y_out !== 8'h20) begin n_fail++; $display("FAIL static_hold_y: got %h expected 20", bus.y_out); end
  endtask

  task automatic test_range;
    bus.x_in = 4'd12; bus.load = 1'b1;
    cyc(1);
    bus.load = 1'b0;
    n_chk++; if (bus.y_out !== 8'h00) begin n_fail++; $display("FAIL oor_y: got %h expected 00", bus.y_out); end
    n_chk++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL oor_err: got %b expected 1", bus.err); end
    cyc(2);
    n_chk++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL oor_err_hold: got %b expected 1", bus.err); end
    bus.x_in = 4'd2; bus.load = 1'b1;
    cyc(1);
    bus.load = 1'b0;
    n_chk++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL inr_err: got %b expected 0", bus.err); end
    n_chk++; if (bus.y_out !== 8'h04) begin n_fail++; $display("FAIL inr_y: got %h expected 04", bus.y_out); end
    bus.mode = 2'b10;
    cyc(1);
    n_chk++; if (bus.y_out !== 8'h07) begin n_fail++; $display("FAIL thermo_y: got %h expected 07", bus.y_out); end
    bus.x_in = 4'd9; bus.load = 1'b1;
    cyc(1);
    bus.load = 1'b0;
    n_chk++; if (bus.y_out !== 8'h00) begin n_fail++; $display("FAIL thermo_oor_y: got %h expected 00", bus.y_out); end
    n_chk++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL thermo_oor_err: got %b expected 1", bus.err); end
    bus.mode = 2'b00; bus.x_in = 4'd7; bus.load = 1'b1;
    cyc(1);
    n_chk++; if (bus.y_out !== 8'h80 || bus.err !== 1'b0) begin n_fail++; $display("FAIL edge7: got y=%h err=%b expected y=80 err=0", bus.y_out, bus.err); end
    bus.x_in = 4'd8;
    cyc(1);
    n_chk++; if (bus.y_out !== 8'h00 || bus.err !== 1'b1) begin n_fail++; $display("FAIL edge8: got y=%h err=%b expected y=00 err=1", bus.y_out, bus.err); end
    bus.x_in = 4'd0;
    cyc(1);
    bus.load = 1'b0;
    n_chk++; if (bus.y_out !== 8'h01 || bus.err !== 1'b0) begin n_fail++; $display("FAIL edge0: got y=%h err=%b expected y=01 err=0", bus.y_out, bus.err); end
  endtask

  task automatic test_scan;
    logic [7:0] ey;
    int         ei;
    bus.mode = 2'b01;
    cyc(1);
    n_chk++; if (bus.idx !== 4'd0 || bus.y_out !== 8'h01) begin n_fail++; $display("FAIL scan_entry: got idx=%0d y=%h expected idx=0 y=01", bus.idx, bus.y_out); end
    for (int c = 1; c <= 33; c++) begin
      cyc(1);
      ei = (c / 4) % 8;
      ey = 8'h01 << ei;
      if (BLANK && (c % 4 == 0)) ey = 8'h00;
      n_chk++; if (bus.idx !== 4'(ei)) begin n_fail++; $display("FAIL scan_idx c=%0d: got %0d expected %0d", c, bus.idx, ei); end
      n_chk++; if (bus.y_out !== ey) begin n_fail++; $display("FAIL scan_y c=%0d: got %h expected %h", c, bus.y_out, ey); end
      n_chk++; if (bus.wrap !== (c == 32)) begin n_fail++; $display("FAIL scan_wrap c=%0d: got %b expected %b", c, bus.wrap, (c == 32)); end
    end
  endtask

  task automatic test_load_tick;
    cyc(2);
    bus.x_in = 4'd3; bus.load = 1'b1;
    cyc(1);
    bus.load = 1'b0;
    n_chk++; if (bus.idx !== 4'd3) begin n_fail++; $display("FAIL lt_idx: got %0d expected 3", bus.idx); end
    n_chk++; if (bus.wrap !== 1'b0) begin n_fail++; $display("FAIL lt_wrap: got %b expected 0", bus.wrap); end
    n_chk++; if (bus.y_out !== (BLANK ? 8'h00 : 8'h08)) begin n_fail++; $display("FAIL lt_y: got %h expected %h", bus.y_out, (BLANK ? 8'h00 : 8'h08)); end
    for (int k = 1; k <= 3; k++) begin
      cyc(1);
      n_chk++; if (bus.idx !== 4'd3 || bus.y_out !== 8'h08) begin n_fail++; $display("FAIL lt_hold k=%0d: got idx=%0d y=%h expected idx=3 y=08", k, bus.idx, bus.y_out); end
    end
    cyc(1);
    n_chk++; if (bus.idx !== 4'd4) begin n_fail++; $display("FAIL lt_step: got %0d expected 4", bus.idx); end
    bus.x_in = 4'd9; bus.load = 1'b1;
    cyc(1);
    bus.load = 1'b0;
    n_chk++; if (bus.idx !== 4'd0 || bus.err !== 1'b1) begin n_fail++; $display("FAIL scan_oor: got idx=%0d err=%b expected idx=0 err=1", bus.idx, bus.err); end
    cyc(1);
    n_chk++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL scan_oor_clear: got %b expected 0", bus.err); end
  endtask

  task automatic test_freeze;
    bus.x_in = 4'd6; bus.load = 1'b1;
    cyc(1);
    bus.load = 1'b0;
    cyc(1);
    n_chk++; if (bus.idx !== 4'd6 || bus.y_out !== 8'h40) begin n_fail++; $display("FAIL frz_pre: got idx=%0d y=%h expected idx=6 y=40", bus.idx, bus.y_out); end
    bus.en = 1'b0; bus.x_in = 4'd2; bus.load = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      n_chk++; if (bus.idx !== 4'd6 || bus.y_out !== 8'h40 || bus.wrap !== 1'b0 || bus.err !== 1'b0) begin
        n_fail++; $display("FAIL frz_hold k=%0d: got idx=%0d y=%h wrap=%b err=%b expected idx=6 y=40 wrap=0 err=0", k, bus.idx, bus.y_out, bus.wrap, bus.err);
      end
    end
    bus.load = 1'b0; bus.en = 1'b1;
    cyc(2);
    n_chk++; if (bus.idx !== 4'd6) begin n_fail++; $display("FAIL frz_resume_hold: got %0d expected 6", bus.idx); end
    cyc(1);
    n_chk++; if (bus.idx !== 4'd7) begin n_fail++; $display("FAIL frz_resume_step: got %0d expected 7", bus.idx); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (bus.y_out !== 8'h00 || bus.idx !== 4'd0) begin n_fail++; $display("FAIL async_rst: got idx=%0d y=%h expected idx=0 y=00", bus.idx, bus.y_out); end
    cyc(1);
    n_chk++; if (bus.y_out !== 8'h00 || bus.idx !== 4'd0) begin n_fail++; $display("FAIL rst_held: got idx=%0d y=%h expected idx=0 y=00", bus.idx, bus.y_out); end
    rst_n = 1'b1;
  endtask

  task automatic test_mode_change;
    bus.mode = 2'b00; bus.x_in = 4'd3; bus.load = 1'b1;
    cyc(1);
    bus.load = 1'b0;
    n_chk++; if (bus.idx !== 4'd3 || bus.y_out !== 8'h08) begin n_fail++; $display("FAIL mc_static: got idx=%0d y=%h expected idx=3 y=08", bus.idx, bus.y_out); end
    bus.mode = 2'b10;
    cyc(1);
    n_chk++; if (bus.idx !== 4'd3 || bus.y_out !== 8'h0f) begin n_fail++; $display("FAIL mc_thermo: got idx=%0d y=%h expected idx=3 y=0f", bus.idx, bus.y_out); end
    bus.mode = 2'b11;
    cyc(1);
    n_chk++; if (bus.idx !== 4'd3 || bus.y_out !== 8'h08) begin n_fail++; $display("FAIL mc_reserved: got idx=%0d y=%h expected idx=3 y=08", bus.idx, bus.y_out); end
  endtask

  initial begin
    test_reset;
    test_static;
    test_range;
    test_scan;
    test_load_tick;
    test_freeze;
    test_mode_change;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
